// File: rtl/seg7_frame_capture_if.sv
// rtl/seg7_frame_capture_if.sv - published-frame bundle of the 7-segment capture block
//
// Signals:
//   digit_bcd   published BCD codes, digit i at [4i+3:4i]
//   digit_err   published per-digit unrecognized-pattern flags
//   frame_valid a published frame awaits acknowledge
//   overrun     sticky: a frame was published over an unacknowledged one
//   frame_ack   consumer acknowledge
// The capture block uses the master modport, the consumer the slave modport.
interface seg7_frame_capture_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] digit_bcd;
  logic [DIGITS-1:0]   digit_err;
  logic                frame_valid;
  logic                overrun;
  logic                frame_ack;

  modport master (
    output digit_bcd,
    output digit_err,
    output frame_valid,
    output overrun,
    input  frame_ack
  );

  modport slave (
    input  digit_bcd,
    input  digit_err,
    input  frame_valid,
    input  overrun,
    output frame_ack
  );
endinterface

// File: rtl/seg7_frame_capture.sv
// rtl/seg7_frame_capture.sv - snoops a multiplexed 7-segment bus and publishes decoded frames
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   seg_n  segment lines, active-low, bit 0 = a .. bit 6 = g (asynchronous)
//   an_n   anode selects, active-low, one per digit (asynchronous)
//   clear  synchronous soft clear of frame assembly and handshake state
//   frm    published frame bundle (digit_bcd, digit_err, frame_valid, overrun, frame_ack)
module seg7_frame_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_n,
  input  logic [DIGITS-1:0] an_n,
  input  logic              clear,
  seg7_frame_capture_if.master frm
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {SCAN, HOLD} state_t;

  state_t state, state_next;

  logic [6:0]        seg_s1, seg_s2, seg_p;
  logic [DIGITS-1:0] an_s1, an_s2, an_p;
  logic [CW-1:0]     cnt, cnt_next;
  logic [DIGITS-1:0] seen, seen_cap;
  logic [4*DIGITS-1:0] shadow_bcd, cap_bcd, bcd_q;
  logic [DIGITS-1:0]   shadow_err, cap_err, err_q;
  logic              fv_q, ov_q;

  logic [DIGITS-1:0] sel;
  logic              dig_valid;
  logic [IW-1:0]     dig_idx;
  logic              changed, capture, publish;
  logic [4:0]        dec;

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = {1'b0, 4'h0};
      7'b1111001: r = {1'b0, 4'h1};
      7'b0100100: r = {1'b0, 4'h2};
      7'b0110000: r = {1'b0, 4'h3};
      7'b0011001: r = {1'b0, 4'h4};
      7'b0010010: r = {1'b0, 4'h5};
      7'b0000010: r = {1'b0, 4'h6};
      7'b1111000: r = {1'b0, 4'h7};
      7'b0000000: r = {1'b0, 4'h8};
      7'b0010000,
      7'b0011000: r = {1'b0, 4'h9};
      7'b1111111: r = {1'b0, 4'hF};
      default:    r = {1'b1, 4'hE};
    endcase
    return r;
  endfunction

  // Two-flop synchronizer plus a third stage holding the previous sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1 <= '1; seg_s2 <= '1; seg_p <= '1;
      an_s1  <= '1; an_s2  <= '1; an_p  <= '1;
    end else begin
      seg_s1 <= seg_n; seg_s2 <= seg_s1; seg_p <= seg_s2;
      an_s1  <= an_n;  an_s2  <= an_s1;  an_p  <= an_s2;
    end
  end

  assign changed = {an_s2, seg_s2} != {an_p, seg_p};
  assign dec     = decode(seg_s2);

  // Exactly one low anode bit names the active digit.
  always_comb begin
    sel       = ~an_s2;
    dig_valid = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
    dig_idx   = '0;
    for (int i = 0; i < DIGITS; i++)
      if (sel[i]) dig_idx = IW'(i);
  end

  // The counter counts equal samples beyond the first; capture happens on
  // the edge it reaches CMAX, i.e. after STABLE_CYCLES identical samples.
  always_comb begin
    cnt_next = cnt;
    if (!dig_valid || changed)
      cnt_next = '0;
    else if (cnt != CMAX)
      cnt_next = cnt + CW'(1);
  end

  assign capture = (state == SCAN) && dig_valid && (cnt_next == CMAX);

  always_comb begin
    state_next = state;
    case (state)
      SCAN: if (capture) state_next = HOLD;
      HOLD: if (changed) state_next = SCAN;
      default: state_next = SCAN;
    endcase
  end

  // Shadow contents with the digit being captured this edge merged in, so a
  // publish on the final capture includes that digit.
  always_comb begin
    cap_bcd  = shadow_bcd;
    cap_err  = shadow_err;
    seen_cap = seen;
    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (dig_idx == IW'(i)) begin
          cap_bcd[4*i +: 4] = dec[3:0];
          cap_err[i]        = dec[4];
          seen_cap[i]       = 1'b1;
        end
      end
    end
  end

  assign publish = capture && (&seen_cap);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SCAN;
      cnt        <= '0;
      seen       <= '0;
      shadow_bcd <= '0;
      shadow_err <= '0;
      bcd_q      <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else if (clear) begin
      state <= SCAN;
      cnt   <= '0;
      seen  <= '0;
      fv_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        shadow_bcd <= cap_bcd;
        shadow_err <= cap_err;
      end
      if (publish) begin
        bcd_q <= cap_bcd;
        err_q <= cap_err;
        seen  <= '0;
        fv_q  <= 1'b1;
        if (fv_q) ov_q <= 1'b1;
      end else begin
        seen <= seen_cap;
        if (frm.frame_ack && fv_q) fv_q <= 1'b0;
      end
    end
  end

  assign frm.digit_bcd   = bcd_q;
  assign frm.digit_err   = err_q;
  assign frm.frame_valid = fv_q;
  assign frm.overrun     = ov_q;
endmodule

// File: tb/tb_seg7_frame_capture.sv
// tb/tb_seg7_frame_capture.sv - self-checking bench for seg7_frame_capture
module tb_seg7_frame_capture;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       clear;

  seg7_frame_capture_if #(.DIGITS(4)) frm ();

  seg7_frame_capture #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seg_n (seg_n),
    .an_n  (an_n),
    .clear (clear),
    .frm   (frm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] bcd;
    logic       err;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  err;
  } exp_t;

  vec_t tbl[16];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic fv_d  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each newly published frame with the oldest expectation.
  always @(negedge clk) begin
    if (frm.frame_valid === 1'b1 && fv_d !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_bcd", {16'h0, frm.digit_bcd}, {16'h0, e.bcd});
        check("frame_err", {28'h0, frm.digit_err}, {28'h0, e.err});
      end
    end
    fv_d <= frm.frame_valid;
  end

  task automatic show(input int d, input logic [6:0] s, input int cycles);
    an_n  = ~(4'b0001 << d);
    seg_n = s;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic show_frame(input logic [27:0] segs, input int dwell);
    for (int d = 0; d < 4; d++) show(d, segs[7*d +: 7], dwell);
  endtask

  task automatic ack();
    frm.frame_ack = 1'b1;
    @(posedge clk); #1;
    frm.frame_ack = 1'b0;
  endtask

  task automatic idle(input int cycles);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic [27:0] segs;

    tbl[0]  = '{7'b1000000, 4'h0, 1'b0};
    tbl[1]  = '{7'b1111001, 4'h1, 1'b0};
    tbl[2]  = '{7'b0100100, 4'h2, 1'b0};
    tbl[3]  = '{7'b0110000, 4'h3, 1'b0};
    tbl[4]  = '{7'b0011001, 4'h4, 1'b0};
    tbl[5]  = '{7'b0010010, 4'h5, 1'b0};
    tbl[6]  = '{7'b0000010, 4'h6, 1'b0};
    tbl[7]  = '{7'b1111000, 4'h7, 1'b0};
    tbl[8]  = '{7'b0000000, 4'h8, 1'b0};
    tbl[9]  = '{7'b0010000, 4'h9, 1'b0};
    tbl[10] = '{7'b0011000, 4'h9, 1'b0};
    tbl[11] = '{7'b1111111, 4'hF, 1'b0};
    tbl[12] = '{7'b0101010, 4'hE, 1'b1};
    tbl[13] = '{7'b1111110, 4'hE, 1'b1};
    tbl[14] = '{7'b0000001, 4'hE, 1'b1};
    tbl[15] = '{7'b1011011, 4'hE, 1'b1};

    // Reset with random inputs
    rst_n = 1'b0;
    clear = 1'b0;
    frm.frame_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      an_n  = 4'($urandom);
      seg_n = 7'($urandom);
      frm.frame_ack = 1'($urandom);
      @(posedge clk); #1;
      check("rst_bcd", {16'h0, frm.digit_bcd}, 32'h0);
      check("rst_err", {28'h0, frm.digit_err}, 32'h0);
      check("rst_fv", {31'h0, frm.frame_valid}, 32'h0);
      check("rst_ov", {31'h0, frm.overrun}, 32'h0);
    end
    rst_n = 1'b1;
    frm.frame_ack = 1'b0;
    idle(4);

    // Normal frame 1234 with publish timing
    e = '{16'h1234, 4'h0};
    sb.push_back(e);
    show(0, 7'b0011001, 20);
    show(1, 7'b0110000, 20);
    show(2, 7'b0100100, 20);
    show(3, 7'b1111001, 9);
    check("fv_before_10th", {31'h0, frm.frame_valid}, 32'h0);
    show(3, 7'b1111001, 1);
    check("fv_on_10th", {31'h0, frm.frame_valid}, 32'h1);
    check("bcd_on_10th", {16'h0, frm.digit_bcd}, 32'h1234);
    show(3, 7'b1111001, 10);
    ack();
    check("fv_after_ack", {31'h0, frm.frame_valid}, 32'h0);

    // Decode table, four digits per frame
    for (int g = 0; g < 4; g++) begin
      for (int d = 0; d < 4; d++) begin
        segs[7*d +: 7] = tbl[4*g+d].seg;
        e.bcd[4*d +: 4] = tbl[4*g+d].bcd;
        e.err[d]        = tbl[4*g+d].err;
      end
      sb.push_back(e);
      show_frame(segs, 14);
      ack();
      check("tbl_fv_cleared", {31'h0, frm.frame_valid}, 32'h0);
    end

    // Glitch rejection
    for (int d = 0; d < 4; d++) show(d, tbl[d].seg, 5);
    an_n  = 4'b1100;
    seg_n = 7'b0000000;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_no_frame", {31'h0, frm.frame_valid}, 32'h0);

    // Special patterns, out of order
    e = '{16'h9E6F, 4'b0100};
    sb.push_back(e);
    show(2, 7'b0101010, 20);
    show(0, 7'b1111111, 20);
    show(1, 7'b0000010, 20);
    show(3, 7'b0011000, 20);
    check("special_fv", {31'h0, frm.frame_valid}, 32'h1);
    ack();

    // Overrun then clear
    e = '{16'h1234, 4'h0};
    sb.push_back(e);
    show_frame({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 20);
    show_frame({7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 20);
    check("ovr_bcd", {16'h0, frm.digit_bcd}, 32'h5678);
    check("ovr_flag", {31'h0, frm.overrun}, 32'h1);
    check("ovr_fv", {31'h0, frm.frame_valid}, 32'h1);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_fv", {31'h0, frm.frame_valid}, 32'h0);
    check("clr_ov", {31'h0, frm.overrun}, 32'h0);
    check("clr_bcd_kept", {16'h0, frm.digit_bcd}, 32'h5678);
    idle(4);

    // Reset mid-frame discards partial captures
    show(0, 7'b0000000, 20);
    show(1, 7'b0000000, 20);
    show(2, 7'b0000000, 20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    show(3, 7'b1111001, 20);
    check("rst_mid_no_frame", {31'h0, frm.frame_valid}, 32'h0);
    e = '{16'h1234, 4'h0};
    sb.push_back(e);
    show(0, 7'b0011001, 20);
    show(1, 7'b0110000, 20);
    show(2, 7'b0100100, 20);
    check("rst_mid_frame", {31'h0, frm.frame_valid}, 32'h1);
    ack();
    idle(4);

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_frame_capture.md
# seg7_frame_capture

Receive side of the multiplexed common-anode 7-segment display bus used by the clock design. The block snoops the segment lines and active-low anode selects, waits for each digit's pattern to be stable, and decodes the pattern back to a 4-bit BCD code. Once every digit position has been captured, it publishes the digits as one frame under a valid/ack handshake. Typical uses are self-checking the display path on the board and reading a display driven by another unit.

## Interface

Parameters:

- DIGITS, 4, number of multiplexed digit positions (2..8).
- STABLE_CYCLES, 8, number of consecutive identical synchronized samples required before a capture (2..255).

Ports:

- clk, input, 1, sole clock; everything is on the rising edge.
- rst_n, input, 1, reset. Synchronous and active-low.
- seg_n, input, 7, segment lines, active-low. Bit 0 = segment a, through bit 6 = segment g. May be asynchronous.
- an_n, input, DIGITS, anode selects, active-low. an_n[i] low selects digit i. May be asynchronous.
- clear, input, 1, synchronous soft clear.
- frame_ack, input, 1, consumer acknowledge of the published frame.
- digit_bcd, output, 4*DIGITS, published codes. Digit i occupies bits [4i+3:4i].
- digit_err, output, DIGITS, published flags; bit i = 1 means digit i held an unrecognized pattern.
- frame_valid, output, 1, a published frame is pending acknowledge.
- overrun, output, 1, sticky flag: a frame was published while frame_valid was still 1.

## Operation

- **Input synchronization.** seg_n and an_n pass through a two-flop synchronizer. All further logic uses only the second stage, referred to below as the sample.
- **Active digit.**
  - A sample has a valid digit only when exactly one an_n bit is low; that bit's index is the digit.
  - Zero or several low bits means no digit. The stability counter is forced to 0 and nothing is captured.
- **Stability counter.**
  - Cleared whenever the current sample {an_n, seg_n} differs from the previous sample.
  - Otherwise it increments, saturating at STABLE_CYCLES-1.
  - Counter width is ceil(log2(STABLE_CYCLES)).
- **Dwell state machine:**
  - SCAN → HOLD when count == STABLE_CYCLES-1 with a valid digit. That edge captures the decode into shadow[i] and sets seen[i].
  - HOLD → SCAN on any sample change. There is exactly one capture per dwell.
  - Any state → SCAN on reset or clear.
- **Decode table** (pattern given as seg_n[6:0]):
  - 1000000 = 0, 1111001 = 1, 0100100 = 2, 0110000 = 3, 0011001 = 4
  - 0010010 = 5, 0000010 = 6, 1111000 = 7, 0000000 = 8
  - 0010000 and 0011000 both = 9
  - 1111111 = F (blank), with err 0
  - Any other pattern = E, with err 1
- **Frame publish.**
  - A frame publishes on the edge where a capture makes seen all-ones.
  - That same edge copies the shadow registers, including the digit being captured on that edge, into digit_bcd and digit_err.
  - On that edge, frame_valid is set to 1 and seen is cleared to 0.
  - Digits may arrive in any order. Recapturing an already-seen digit updates its shadow entry only.
- **Handshake.**
  - frame_valid is cleared on the edge after frame_ack is sampled at 1.
  - frame_ack while frame_valid is 0 is ignored.
  - Publishing while frame_valid is 1 overwrites the outputs, keeps frame_valid at 1, and sets overrun.
  - If publish and ack occur on the same edge, publish wins: frame_valid stays 1 and overrun is set.
- **Clear.** Zeroes seen, counter, frame_valid and overrun, and returns the state machine to SCAN. digit_bcd, digit_err and the shadow registers are unchanged.

## Timing

- **Reset values:** digit_bcd = 0, digit_err = 0, frame_valid = 0, overrun = 0, state = SCAN, seen = 0, counter = 0, synchronizer flops = all ones.
- **Capture latency:** capture occurs STABLE_CYCLES+2 edges after the pins settle at a new value (2 synchronizer edges, then STABLE_CYCLES equal samples).
  - With the default of 8, a dwell of 10 cycles or more is always captured.
  - A dwell of fewer than STABLE_CYCLES synchronized cycles is never captured.
- **Publish latency:** frame_valid and digit_bcd update on the same edge as the final capture. No extra output pipeline stage.
- **Ack latency:** frame_valid falls 1 cycle after frame_ack is high.
- **Reset mid-dwell:** a partial frame is discarded. The next frame requires fresh captures of all digits.

## Test plan

1. **Reset.** Hold rst_n low 3 cycles with random inputs → all outputs 0 and frame_valid 0 for the whole time.
2. **Normal frame** (DIGITS=4, STABLE_CYCLES=8). Dwell 20 cycles each on an_n = 1110 / 1101 / 1011 / 0111 showing 0011001 / 0110000 / 0100100 / 1111001 → digit_bcd = 16'h1234, digit_err = 0, frame_valid rises on the 10th cycle of digit 3's dwell. frame_ack for 1 cycle → frame_valid is 0 on the following cycle.
3. **Glitch rejection.** Present each digit for only 5 cycles, plus an_n = 1100 for 30 cycles → no capture, frame_valid stays 0.
4. **Special patterns.** Show 0101010 on digit 2, 1111111 on digit 0, 0000010 on digit 1 and 0011000 on digit 3 → digit_bcd = 16'h9E6F, digit_err = 4'b0100.
5. **Overrun and clear.** Two full frames with no ack (second shows 5678) → digit_bcd = 16'h5678, overrun = 1, frame_valid = 1. Then clear → frame_valid = 0, overrun = 0, digit_bcd still 16'h5678.
6. **Reset mid-frame.** Capture digits 0–2, pulse rst_n low, then capture only digit 3 → frame_valid stays 0. After digits 0–2 are recaptured → frame_valid = 1.
